// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder computing a + b + cin, LSB first,
// with one full-adder cell and a carry flip-flop.
// Latency: done pulses WIDTH cycles after start is accepted; a start issued
// during the done cycle is accepted (one result per WIDTH+1 cycles).
// Backpressure: none. start is ignored while busy=1; sum/cout hold until the
// next completion.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous, active-high reset
//   start - request, sampled only while busy=0 (IDLE or DONE)
//   a, b  - operands, captured when start is accepted
//   cin   - carry-in, captured when start is accepted
//   busy  - high while bit steps are in progress
//   done  - one-cycle pulse when sum/cout (and ovf) become valid
//   sum   - result bits [WIDTH-1:0], held until the next completion
//   cout  - carry out of the MSB, held with sum
//   ovf   - signed overflow flag, held with sum
//           (port present only when SERIAL_ADDER_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q,  res_d;
  logic             c_q,    c_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,  ovf_d;
`endif

  // Single full-adder cell working on the current LSBs and the carry flop.
  logic fa_s;
  logic fa_c;

  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // Both non-busy states accept a request; DONE falls back to IDLE
        // otherwise, which limits done to a single cycle.
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_c;
        // Sum bits enter at the MSB so that after WIDTH steps the first
        // (LSB) bit has travelled down to position 0.
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish the completed word directly from the shifter input so
          // sum never exposes a partially built result.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB during the last step.
          ovf_d   = c_q ^ fa_c;
`endif
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed cases plus randomized
// operands checked against a plain-arithmetic reference model.
// Optional overflow output is exercised when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  // Last completed result, which sum/cout must hold while a new op runs.
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: true (WIDTH+1)-bit sum of the operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  // Signed overflow: operands share a sign that the result does not.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    logic [W:0] r;
    r = ref_add(x, y, ci);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Runs one operation. Entered and left just after a falling edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input string name);
    logic [W:0] exp;
    logic       bad_busy;
    exp      = ref_add(ta, tb_v, tc);
    bad_busy = 1'b0;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    @(posedge clk);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Scramble inputs after acceptance: result in flight must not care.
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
      end
      if (busy !== 1'b1 || done !== 1'b0 || sum !== prev_sum || cout !== prev_cout)
        bad_busy = 1'b1;
    end
    checks++;
    if (bad_busy) begin
      errors++;
      $display("FAIL %s busy_phase: busy/done/held-result wrong during run, required busy=1 done=0 sum=%h cout=%b",
               name, prev_sum, prev_cout);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b, required done=1 busy=0 at cycle %0d",
               name, done, busy, W);
    end
    checks++;
    if (sum !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s sum: got %h, required %h", name, sum, exp[W-1:0]);
    end
    checks++;
    if (cout !== exp[W]) begin
      errors++;
      $display("FAIL %s cout: got %b, required %b", name, cout, exp[W]);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== ref_ovf(ta, tb_v, tc)) begin
      errors++;
      $display("FAIL %s ovf: got %b, required %b", name, ovf, ref_ovf(ta, tb_v, tc));
    end
`endif
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: done=%b busy=%b, required done=0 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: sum=%h cout=%b, required 00 0", sum, cout);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b, required 0", ovf);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'h0F, 8'h01, 1'b0, "add_0f_01");
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h00, 8'h00, 1'b1, "add_cin_only");
    run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
  endtask

  task automatic test_start_while_busy();
    int n_done;
    n_done = 0;
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= W + 10; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done === 1'b1) n_done++;
      if (k == W) begin
        checks++;
        if (done !== 1'b1 || sum !== 8'h46 || cout !== 1'b0) begin
          errors++;
          $display("FAIL busy_ignore_result: done=%b sum=%h cout=%b, required 1 46 0", done, sum, cout);
        end
      end
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL busy_ignore_pulses: got %0d done pulses, required 1", n_done);
    end
    prev_sum  = 8'h46;
    prev_cout = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    prev_sum  = '0;
    prev_cout = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, required 0", n_done);
    end
    run_op(8'h80, 8'h80, 1'b0, "after_reset_80_80");
  endtask

  task automatic test_back_to_back();
    logic bad1;
    logic bad2;
    bad1 = 1'b0;
    bad2 = 1'b0;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    @(posedge clk);
    for (int k = 0; k <= 2 * W + 2; k++) begin
      @(negedge clk);
      if (k < W) begin
        if (busy !== 1'b1 || done !== 1'b0) bad1 = 1'b1;
      end else if (k == W) begin
        checks++;
        if (done !== 1'b1 || sum !== 8'h02 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first: done=%b sum=%h cout=%b, required 1 02 0", done, sum, cout);
        end
        a = 8'h02;
        b = 8'h03;
      end else if (k <= 2 * W) begin
        if (k == W + 1) start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h02) bad2 = 1'b1;
      end else if (k == 2 * W + 1) begin
        checks++;
        if (done !== 1'b1 || sum !== 8'h05 || cout !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second: done=%b sum=%h cout=%b, required 1 05 0 at cycle %0d", done, sum, cout, k);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle: done=%b busy=%b, required 0 0", done, busy);
        end
      end
    end
    checks++;
    if (bad1) begin
      errors++;
      $display("FAIL b2b_run1: busy/done wrong during first op, required busy=1 done=0");
    end
    checks++;
    if (bad2) begin
      errors++;
      $display("FAIL b2b_run2: busy/done/held sum wrong during second op, required busy=1 done=0 sum=02");
    end
    prev_sum  = 8'h05;
    prev_cout = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) @(negedge clk);
      run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
